serial_tx: RTL and testbench



---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_tx_bit_timer.sv | 27 ++
 rtl/serial_tx.sv | 113 +++++++++++
 tb/tb_serial_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and line levels for the serial transmitter
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// rtl/serial_tx_bit_timer.sv - per-bit cycle counter producing a terminal-count tick
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Count while enabled, wrap at terminal count, hold at zero while idle
  always_ff @(posedge clk) begin
    if (rst || !en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-in serial-out frame transmitter (start, LSB-first data, stop)
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic             tx_next, ready_next, busy_next, done_next;
  logic             tick;

  // The timer runs for the whole frame; it is already at zero on the accept edge
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .tick(tick)
  );

  // State, shift register and all outputs are registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx      <= LINE_IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      tx      <= tx_next;
      ready   <= ready_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // Next-state logic: every line change happens on a bit-timer tick except the accept
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    tx_next      = tx;
    ready_next   = ready;
    busy_next    = busy;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          state_next   = START;
          shreg_next   = data_in;
          bit_cnt_next = '0;
          tx_next      = LINE_START;
          ready_next   = 1'b0;
          busy_next    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          tx_next      = shreg[0];
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_next = STOP;
            tx_next    = LINE_IDLE;
          end else begin
            // Shift first so the new LSB is the bit going out next
            shreg_next   = shreg >> 1;
            tx_next      = shreg_next[0];
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          tx_next    = LINE_IDLE;
          ready_next = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - self-checking bench for serial_tx against a frame-level reference model
module tb_serial_tx;

  localparam int W   = 8;
  localparam int CPB = 4;
  localparam int FL  = (W + 2) * CPB;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [W-1:0] data_in;
  logic         ready, tx, busy, done;
  logic         s1 = 1'b1, s2 = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .valid  (valid),
    .ready  (ready),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Two-stage capture chain feeding the loopback sampler
  always @(posedge clk) begin
    s1 <= tx;
    s2 <= s1;
  end

  // Expected line level c cycles after the accept edge
  function automatic logic frame_bit(input logic [W-1:0] w, input int c);
    int k;
    k = c / CPB;
    if (k == 0) return 1'b0;
    else if (k <= W) return w[k-1];
    else return 1'b1;
  endfunction

  // Present a word; returns at the negedge just after the accept edge
  task automatic start_word(input logic [W-1:0] w);
    data_in = w;
    valid   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b1; data_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({tx, ready, busy, done} !== 4'b1100) begin
        n_bad++;
        $display("FAIL reset[%0d]: tx/ready/busy/done got %b expected 1100", i, {tx, ready, busy, done});
      end
    end
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({tx, ready, busy} !== 3'b110) begin
      n_bad++;
      $display("FAIL reset_release: tx/ready/busy got %b expected 110", {tx, ready, busy});
    end
  endtask

  task automatic test_single_frame(input logic [W-1:0] w);
    start_word(w);
    valid = 1'b0;
    data_in = W'($urandom);
    for (int c = 0; c < FL; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp++;
      if (tx !== frame_bit(w, c) || busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL frame_%h[%0d]: tx/busy/done got %b%b%b expected %b10", w, c, tx, busy, done, frame_bit(w, c));
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({tx, ready, busy, done} !== 4'b1101) begin
      n_bad++;
      $display("FAIL frame_%h_done: tx/ready/busy/done got %b expected 1101", w, {tx, ready, busy, done});
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_%h_done_width: done got %b expected 0", w, done);
    end
  endtask

  task automatic test_ignored;
    int starts;
    start_word(8'h3C);
    valid = 1'b0;
    for (int c = 0; c < FL; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp++;
      if (tx !== frame_bit(8'h3C, c)) begin
        n_bad++;
        $display("FAIL ignored[%0d]: tx got %b expected %b", c, tx, frame_bit(8'h3C, c));
      end
      if (c == 10) begin valid = 1'b1; data_in = 8'hFF; end
      if (c == 20) valid = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL ignored_done: done got %b expected 1", done);
    end
    starts = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1) starts++;
    end
    n_cmp++;
    if (starts != 0) begin
      n_bad++;
      $display("FAIL ignored_no_second: non-idle cycles got %0d expected 0", starts);
    end
  endtask

  task automatic test_back_to_back;
    start_word(8'h00);
    data_in = 8'hFF;
    for (int c = 0; c < FL; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp++;
      if (tx !== frame_bit(8'h00, c)) begin
        n_bad++;
        $display("FAIL b2b_first[%0d]: tx got %b expected %b", c, tx, frame_bit(8'h00, c));
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({tx, done} !== 2'b11) begin
      n_bad++;
      $display("FAIL b2b_gap: tx/done got %b expected 11", {tx, done});
    end
    @(negedge clk);
    valid = 1'b0;
    n_cmp++;
    if ({tx, ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_second_start: tx/ready got %b expected 00", {tx, ready});
    end
    for (int c = 1; c < FL; c++) begin
      @(negedge clk);
      n_cmp++;
      if (tx !== frame_bit(8'hFF, c)) begin
        n_bad++;
        $display("FAIL b2b_second[%0d]: tx got %b expected %b", c, tx, frame_bit(8'hFF, c));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second_done: done got %b expected 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int bad_idle;
    start_word(8'h55);
    valid = 1'b0;
    for (int c = 0; c < 17; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp++;
      if (tx !== frame_bit(8'h55, c)) begin
        n_bad++;
        $display("FAIL midrst_pre[%0d]: tx got %b expected %b", c, tx, frame_bit(8'h55, c));
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({tx, ready, busy, done} !== 4'b1100) begin
      n_bad++;
      $display("FAIL midrst_edge: tx/ready/busy/done got %b expected 1100", {tx, ready, busy, done});
    end
    bad_idle = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || done !== 1'b0) bad_idle++;
    end
    n_cmp++;
    if (bad_idle != 0) begin
      n_bad++;
      $display("FAIL midrst_quiet: bad cycles got %0d expected 0", bad_idle);
    end
    test_single_frame(8'h01);
  endtask

  task automatic test_loopback;
    logic [W-1:0] w, got;
    logic         sb, pb;
    int           dones, waited;
    dones = 0;
    for (int n = 0; n < 16; n++) begin
      w = W'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_word(w);
      valid = 1'b0;
      got = '0; sb = 1'b1; pb = 1'b0;
      for (int c = 0; c <= FL; c++) begin
        if (c > 0) @(negedge clk);
        if (done === 1'b1) dones++;
        for (int k = 0; k < W + 2; k++) begin
          if (c == k * CPB + CPB / 2 + 2) begin
            if (k == 0) sb = s2;
            else if (k <= W) got[k-1] = s2;
            else pb = s2;
          end
        end
      end
      n_cmp++;
      if (got !== w || sb !== 1'b0 || pb !== 1'b1) begin
        n_bad++;
        $display("FAIL loopback[%0d]: word/start/stop got %h/%b/%b expected %h/0/1", n, got, sb, pb, w);
      end
      waited = 0;
      while (ready !== 1'b1 && waited < 10) begin
        @(negedge clk);
        if (done === 1'b1) dones++;
        waited++;
      end
      if (waited >= 10) begin
        n_cmp++;
        n_bad++;
        $display("FAIL loopback_ready_timeout[%0d]: ready got %b expected 1", n, ready);
      end
    end
    n_cmp++;
    if (dones != 16) begin
      n_bad++;
      $display("FAIL loopback_done_count: got %0d expected 16", dones);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data_in = '0;
    test_reset();
    test_single_frame(8'hA5);
    test_single_frame(W'($urandom));
    test_ignored();
    test_back_to_back();
    test_mid_reset();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
